fifo_width_conv: RTL
====================

FIFO_WIDTH_CONV -- requirements
Module: fifo_width_conv

Interface
REQ-001 The block SHALL have parameter OUT_W, default 8, meaning output word width in bits.
REQ-002 The block SHALL have parameter RATIO, default 2, meaning output words per input word; IN_W = OUT_W*RATIO; RATIO is a power of two, 1..DEPTH.
REQ-003 The block SHALL have parameter DEPTH, default 16, meaning storage capacity in output words; a power of two, at least 4.
REQ-004 The block SHALL have parameter MSB_FIRST, default 1, meaning output order: 1 = most-significant slice of each input word first; 0 = least-significant first.
REQ-005 The block SHALL have parameter AF_LEVEL, default DEPTH-RATIO, meaning the almost_full threshold in output words.
REQ-006 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rstn, input, 1, meaning the asynchronous active-low reset.
REQ-008 The block SHALL have port flush, input, 1, meaning synchronous clear of all contents.
REQ-009 The block SHALL have port data_in, input, IN_W, meaning the wide write word.
REQ-010 The block SHALL have port input_valid, input, 1, meaning the producer offers data_in.
REQ-011 The block SHALL have port input_enable, output, 1, meaning the block accepts a wide word this cycle.
REQ-012 The block SHALL have port data_out, output, OUT_W, meaning the head output word.
REQ-013 The block SHALL have port output_valid, output, 1, meaning data_out holds a valid word.
REQ-014 The block SHALL have port output_enable, input, 1, meaning the consumer takes data_out this cycle.
REQ-015 The block SHALL have port level, output, clog2(DEPTH)+1, meaning the stored output-word count.
REQ-016 The block SHALL have port almost_full, output, 1, meaning level >= AF_LEVEL.

Function
REQ-017 Push SHALL occur when input_valid && input_enable; it stores RATIO slices, ordered per MSB_FIRST.
REQ-018 Pop SHALL occur when output_valid && output_enable; it removes one output word.
REQ-019 input_enable SHALL equal (DEPTH - level) >= RATIO, from registered level only (no same-cycle pop credit).
REQ-020 output_valid SHALL equal level != 0; data_out SHALL be the head word (first-word-fall-through) and SHALL read 0 while output_valid = 0.
REQ-021 Latency: a word pushed at edge N SHALL be visible on data_out/output_valid after edge N.
REQ-022 Simultaneous push and pop SHALL update level by +RATIO-1 in one edge.
REQ-023 Pop with level = 0, and push with input_enable = 0, SHALL have no effect.
REQ-024 Write and read pointers SHALL wrap modulo DEPTH with word order preserved.
REQ-025 flush = 1 SHALL set level and both pointers to 0 at the next edge, overriding any concurrent push or pop.
REQ-026 almost_full and level SHALL be registered or derived only from registered state, with no combinational path from input_valid or output_enable.

Reset
REQ-027 While rstn = 0, the block SHALL hold level = 0, pointers = 0, output_valid = 0, data_out = 0, input_enable = 1 and almost_full = (AF_LEVEL = 0).
REQ-028 Reset mid-operation SHALL discard all contents immediately, without waiting for a clock edge.
REQ-029 Memory array contents SHALL NOT be reset.

Structure
REQ-030 The shared package fifo_pkg SHALL hold the MSB_FIRST/LSB_FIRST mode constants and a clog2 function.
REQ-031 Storage SHALL be one sub-module, fifo_conv_ram, with a RATIO-slice write port and a single-word read port, both on clk.

Verification (defaults unless stated)
REQ-032 Reset: assert rstn = 0 mid-traffic at level 6 -> level = 0, output_valid = 0, input_enable = 1 immediately.
REQ-033 Ordering: push 16'hA55A with output_enable = 0 -> next cycle level = 2, data_out = 8'hA5; pop -> 8'h5A; with MSB_FIRST = 0, order is 8'h5A then 8'hA5.
REQ-034 Full: 8 pushes with no pops -> level = 16, input_enable = 0, almost_full = 1; a further input_valid leaves contents unchanged.
REQ-035 Simultaneous: push plus pop at level 4 -> level 5, and the popped word is the previous head.
REQ-036 Flush: flush plus push at level 10 -> level 0 and output_valid = 0 next cycle; the pushed word is discarded.
REQ-037 Wrap: 40 random push/pop cycles with RATIO = 4, DEPTH = 8 -> scoreboard order matches and level never exceeds 8.

Source files
------------

// File: rtl/fifo_pkg.sv
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared constants and helpers for the width-converting FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

  // Output ordering modes for the slices of one wide input word
  localparam int MODE_LSB_FIRST = 0;
  localparam int MODE_MSB_FIRST = 1;

  // Ceiling log2, usable in constant expressions; clog2(1) = 0
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_conv_ram.sv
// ============================================================================
// Module   : fifo_conv_ram
// Purpose  : Storage for the width-converting FIFO. One write writes RATIO
//            consecutive output words; the read port returns one word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_conv_ram
  import fifo_pkg::*;
#(
  parameter int OUT_W = 8,
  parameter int RATIO = 2,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       wr_en_i,
  input  logic [clog2(DEPTH)-1:0]    wr_addr_i,
  input  logic [OUT_W*RATIO-1:0]     wr_data_i,
  input  logic [clog2(DEPTH)-1:0]    rd_addr_i,
  output logic [OUT_W-1:0]           rd_data_o
);

  localparam int AW = clog2(DEPTH);

  // Contents are deliberately left unreset; level tracking defines validity.
  logic [OUT_W-1:0] mem_q [DEPTH];

  // Write slice k of the wide word to address wr_addr + k (modulo DEPTH)
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int k = 0; k < RATIO; k++) begin
        mem_q[wr_addr_i + AW'(k)] <= wr_data_i[k*OUT_W +: OUT_W];
      end
    end
  end

  // Read is address-driven so a freshly written head is visible right away
  assign rd_data_o = mem_q[rd_addr_i];

endmodule

`default_nettype wire

// File: rtl/fifo_width_conv.sv
// ============================================================================
// Module   : fifo_width_conv
// Purpose  : First-word-fall-through FIFO that accepts OUT_W*RATIO-bit words
//            and delivers them as RATIO consecutive OUT_W-bit words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_width_conv
  import fifo_pkg::*;
#(
  parameter int OUT_W     = 8,
  parameter int RATIO     = 2,
  parameter int DEPTH     = 16,
  parameter int MSB_FIRST = 1,
  parameter int AF_LEVEL  = DEPTH - RATIO
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic [OUT_W*RATIO-1:0]   data_in,
  input  logic                     input_valid,
  output logic                     input_enable,
  output logic [OUT_W-1:0]         data_out,
  output logic                     output_valid,
  input  logic                     output_enable,
  output logic [clog2(DEPTH):0]    level,
  output logic                     almost_full
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [LW-1:0] RATIO_L  = LW'(RATIO);
  localparam logic [LW-1:0] AF_L     = LW'(AF_LEVEL);
  // When RATIO == DEPTH the step truncates to 0, which is a full lap.
  localparam logic [AW-1:0] PTR_STEP = AW'(RATIO);

  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q,  level_d;
  logic                   w_push;
  logic                   w_pop;
  logic [OUT_W*RATIO-1:0] w_wr_data;
  logic [OUT_W-1:0]       w_rd_data;

  // Status is derived from registered level only: no input-to-output path.
  assign input_enable = (DEPTH_L - level_q) >= RATIO_L;
  assign output_valid = (level_q != '0);
  assign almost_full  = (level_q >= AF_L);
  assign level        = level_q;
  assign data_out     = output_valid ? w_rd_data : '0;

  assign w_push = input_valid & input_enable;
  assign w_pop  = output_valid & output_enable;

  // Reorder the wide word so that slice 0 is the first word to be read out
  for (genvar k = 0; k < RATIO; k++) begin : g_slice
    if (MSB_FIRST == MODE_MSB_FIRST) begin : g_msb
      assign w_wr_data[k*OUT_W +: OUT_W] = data_in[(RATIO-1-k)*OUT_W +: OUT_W];
    end else begin : g_lsb
      assign w_wr_data[k*OUT_W +: OUT_W] = data_in[k*OUT_W +: OUT_W];
    end
  end

  fifo_conv_ram #(
    .OUT_W (OUT_W),
    .RATIO (RATIO),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (w_push & ~flush),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (w_wr_data),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (w_rd_data)
  );

  // Next-state for pointers and level; flush overrides push and pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + PTR_STEP;
      if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + (w_push ? RATIO_L : '0) - (w_pop ? LW'(1) : '0);
    end
  end

  // State registers; reset empties the FIFO without waiting for a clock
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

`default_nettype wire
